// File: rtl/ldpc_pkg.sv
// Shared types and the LLR saturation helper for the intrinsic-message RAM loader.
package ldpc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ld_state_t;

    localparam int LD_IN_WIDTH   = 8;
    localparam int LD_DATA_WIDTH = 5;
    localparam int MSG_MAX       = 2**(LD_DATA_WIDTH-1) - 1;

    // Symmetric clip so the most negative code of the narrow format is never produced.
    function automatic int sat_llr(input int x, input int msg_max);
        if (x > msg_max) begin
            return msg_max;
        end
        if (x < -msg_max) begin
            return -msg_max;
        end
        return x;
    endfunction

endpackage

// File: rtl/int_ram_loader_if.sv
// Valid/ready stream of channel LLRs between the source and the RAM loader.
interface int_ram_loader_if #(
    parameter int IN_WIDTH = 8
);
    logic signed [IN_WIDTH-1:0] llr_in;
    logic                       llr_valid;
    logic                       llr_last;
    logic                       llr_ready;

    modport master (output llr_in, output llr_valid, output llr_last, input llr_ready);
    modport slave  (input llr_in, input llr_valid, input llr_last, output llr_ready);
endinterface

// File: rtl/int_ram_loader.sv
// Ping-pong writer of saturated channel LLRs into two intrinsic RAM banks.
// Optional beat-clip counter on port sat_cnt is enabled by defining SAT_COUNT_EN.
module int_ram_loader
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH   = LD_IN_WIDTH,
    parameter int DATA_WIDTH = LD_DATA_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    int_ram_loader_if.slave       llr,
    input  logic [1:0]            bank_free,
    output logic [1:0]            bank_full,
    output logic [ADDR_WIDTH-1:0] ram_addr [2],
    output logic [DATA_WIDTH-1:0] ram_data [2],
    output logic                  ram_we   [2],
    output logic                  ram_cs   [2],
    output logic                  frame_err
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]           sat_cnt
`endif
);

    localparam int                    MSG_LIM  = 2**(DATA_WIDTH-1) - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    ld_state_t             state;
    ld_state_t             state_next;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  beat;
    logic                  final_beat;
    logic signed [IN_WIDTH-1:0] llr_s;
    int                    llr_int;
    int                    sat_int;

    assign llr_s      = llr.llr_in;
    assign llr_int    = int'(llr_s);
    assign sat_int    = sat_llr(llr_int, MSG_LIM);
    assign beat       = llr.llr_valid && (state == LOAD);
    assign final_beat = beat && (cnt == LAST_IDX);

    // Only an empty target bank lets the loader open the stream.
    always_comb begin
        state_next    = state;
        llr.llr_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!bank_full[wr_bank]) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                llr.llr_ready = 1'b1;
                if (final_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_bank   <= 1'b0;
            cnt       <= '0;
            bank_full <= 2'b00;
            frame_err <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ram_addr[i] <= '0;
                ram_data[i] <= '0;
                ram_we[i]   <= 1'b0;
                ram_cs[i]   <= 1'b0;
            end
        end else begin
            state     <= state_next;
            frame_err <= beat && (llr.llr_last != (cnt == LAST_IDX));
            // Bank ports return to zero unless this cycle carried a beat.
            for (int i = 0; i < 2; i++) begin
                ram_addr[i] <= '0;
                ram_data[i] <= '0;
                ram_we[i]   <= 1'b0;
                ram_cs[i]   <= 1'b0;
                if (bank_free[i]) begin
                    bank_full[i] <= 1'b0;
                end
                if (beat && (int'(wr_bank) == i)) begin
                    ram_addr[i] <= cnt;
                    ram_data[i] <= DATA_WIDTH'(sat_int);
                    ram_we[i]   <= 1'b1;
                    ram_cs[i]   <= 1'b1;
                    if (final_beat) begin
                        bank_full[i] <= 1'b1;
                    end
                end
            end
            if (final_beat) begin
                cnt     <= '0;
                wr_bank <= ~wr_bank;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (state == IDLE && state_next == LOAD) begin
            sat_cnt <= '0;
        end else if (beat && (sat_int != llr_int) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_int_ram_loader.sv
// Directed bench for int_ram_loader with FRAME_LEN=4: reset, saturation, ping-pong, release, framing, gaps.
module tb_int_ram_loader;

    logic       clk;
    logic       rst_n;
    logic [1:0] bank_free;
    logic [1:0] bank_full;
    logic [7:0] ram_addr [2];
    logic [4:0] ram_data [2];
    logic       ram_we   [2];
    logic       ram_cs   [2];
    logic       frame_err;
`ifdef SAT_COUNT_EN
    logic [15:0] sat_cnt;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] P15 = 5'd15;
    localparam logic [4:0] M15 = 5'b10001;

    int_ram_loader_if #(.IN_WIDTH(8)) llr_bus ();

    int_ram_loader #(
        .IN_WIDTH(8), .DATA_WIDTH(5), .ADDR_WIDTH(8), .FRAME_LEN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .llr(llr_bus.slave),
        .bank_free(bank_free), .bank_full(bank_full),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_cs(ram_cs),
        .frame_err(frame_err)
`ifdef SAT_COUNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stream inputs, then sample 1 ns after the edge.
    task automatic applyStimulus(input int value, input logic valid, input logic last);
        llr_bus.llr_in    = 8'(value);
        llr_bus.llr_valid = valid;
        llr_bus.llr_last  = last;
        @(posedge clk);
        #1;
        llr_bus.llr_valid = 1'b0;
        llr_bus.llr_last  = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input int b, input int addr, input logic [4:0] data);
        checkOutput({tag, "_we"},    32'(ram_we[b]),     32'd1);
        checkOutput({tag, "_cs"},    32'(ram_cs[b]),     32'd1);
        checkOutput({tag, "_addr"},  32'(ram_addr[b]),   32'(addr));
        checkOutput({tag, "_data"},  32'(ram_data[b]),   32'(data));
        checkOutput({tag, "_other"}, 32'(ram_we[1-b]),   32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bank_free         = 2'b00;
        llr_bus.llr_in    = '0;
        llr_bus.llr_valid = 1'b0;
        llr_bus.llr_last  = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("rst_ready", 32'(llr_bus.llr_ready), 32'd0);
        checkOutput("rst_full",  32'(bank_full),         32'd0);

        // T1: reset in the middle of a frame
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t1_ready", 32'(llr_bus.llr_ready), 32'd1);
        applyStimulus(9, 1'b1, 1'b0);
        checkWrite("t1_b0", 0, 0, 5'd9);
        applyStimulus(4, 1'b1, 1'b0);
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t1_rst_ready", 32'(llr_bus.llr_ready), 32'd0);
        checkOutput("t1_rst_full",  32'(bank_full),         32'd0);
        checkOutput("t1_rst_we0",   32'(ram_we[0]),         32'd0);
        checkOutput("t1_rst_addr0", 32'(ram_addr[0]),       32'd0);
        checkOutput("t1_rst_data0", 32'(ram_data[0]),       32'd0);
        checkOutput("t1_rst_ferr",  32'(frame_err),         32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t1_restart", 32'(llr_bus.llr_ready), 32'd1);

        // T2/T3: frame into bank 0 with clipping
        applyStimulus(100, 1'b1, 1'b0);
        checkWrite("t2_a", 0, 0, P15);
        applyStimulus(-100, 1'b1, 1'b0);
        checkWrite("t2_b", 0, 1, M15);
        applyStimulus(15, 1'b1, 1'b0);
        checkWrite("t2_c", 0, 2, P15);
        applyStimulus(-16, 1'b1, 1'b1);
        checkWrite("t2_d", 0, 3, M15);
        checkOutput("t3_full01", 32'(bank_full),         32'd1);
        checkOutput("t3_gap",    32'(llr_bus.llr_ready), 32'd0);
        checkOutput("t3_ferr0",  32'(frame_err),         32'd0);
`ifdef SAT_COUNT_EN
        checkOutput("sat_cnt", 32'(sat_cnt), 32'd3);
`endif
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t3_ready1", 32'(llr_bus.llr_ready), 32'd1);
        checkOutput("t3_idle_we", 32'(ram_we[0]), 32'd0);
        checkOutput("t3_idle_data", 32'(ram_data[0]), 32'd0);

        // T3: second frame into bank 1
        applyStimulus(-15, 1'b1, 1'b0);
        checkWrite("t3_e", 1, 0, M15);
        applyStimulus(0, 1'b1, 1'b0);
        checkWrite("t3_f", 1, 1, 5'd0);
        applyStimulus(7, 1'b1, 1'b0);
        checkWrite("t3_g", 1, 2, 5'd7);
        applyStimulus(-1, 1'b1, 1'b1);
        checkWrite("t3_h", 1, 3, 5'h1f);
        checkOutput("t3_full11", 32'(bank_full), 32'd3);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t3_park", 32'(llr_bus.llr_ready), 32'd0);

        // T4: release bank 0
        bank_free = 2'b01;
        applyStimulus(0, 1'b0, 1'b0);
        bank_free = 2'b00;
        checkOutput("t4_full10", 32'(bank_full), 32'd2);
        checkOutput("t4_not_yet", 32'(llr_bus.llr_ready), 32'd0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t4_ready", 32'(llr_bus.llr_ready), 32'd1);

        // T5: early and missing llr_last
        applyStimulus(5, 1'b1, 1'b0);
        checkOutput("t5_err_a", 32'(frame_err), 32'd0);
        applyStimulus(6, 1'b1, 1'b1);
        checkOutput("t5_err_early", 32'(frame_err), 32'd1);
        applyStimulus(7, 1'b1, 1'b0);
        checkOutput("t5_err_c", 32'(frame_err), 32'd0);
        applyStimulus(8, 1'b1, 1'b0);
        checkWrite("t5_d", 0, 3, 5'd8);
        checkOutput("t5_err_missing", 32'(frame_err), 32'd1);
        checkOutput("t5_full11", 32'(bank_full), 32'd3);

        // T6: free bank 1, then fill it with valid gaps and a stray free on the empty bank
        bank_free = 2'b10;
        applyStimulus(0, 1'b0, 1'b0);
        bank_free = 2'b00;
        checkOutput("t6_full01", 32'(bank_full), 32'd1);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t6_ready", 32'(llr_bus.llr_ready), 32'd1);
        applyStimulus(3, 1'b1, 1'b0);
        checkWrite("t6_a", 1, 0, 5'd3);
        bank_free = 2'b10;
        applyStimulus(0, 1'b0, 1'b0);
        bank_free = 2'b00;
        checkOutput("t6_gap_we1", 32'(ram_we[1]), 32'd0);
        checkOutput("t6_gap_we0", 32'(ram_we[0]), 32'd0);
        checkOutput("t6_stray_free", 32'(bank_full), 32'd1);
        applyStimulus(-128, 1'b1, 1'b0);
        checkWrite("t6_b", 1, 1, M15);
        applyStimulus(127, 1'b1, 1'b0);
        checkWrite("t6_c", 1, 2, P15);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t6_gap2_we1", 32'(ram_we[1]), 32'd0);
        applyStimulus(1, 1'b1, 1'b1);
        checkWrite("t6_d", 1, 3, 5'd1);
        checkOutput("t6_ferr", 32'(frame_err), 32'd0);
        checkOutput("t6_full11", 32'(bank_full), 32'd3);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t6_park", 32'(llr_bus.llr_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
